// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core. It includes the load-use hazard detector,
// flush handling and a saturating bubble counter for performance debugging.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic              RegDst,
   input  logic              J,
   input  logic              Beq,
   input  logic              Bneq,
   input  logic              MemRead,
   input  logic              MemtoReg,
   input  logic              MemWrite,
   input  logic              RegWrite,
   input  logic [1:0]        Alu_src,
   input  logic [2:0]        Alu_op,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imm,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [4:0]        id_shamt,
   input  logic [5:0]        id_funct,
   input  logic              flush,
   output logic              ex_valid,
   output logic              ex_RegDst,
   output logic              ex_J,
   output logic              ex_Beq,
   output logic              ex_Bneq,
   output logic              ex_MemRead,
   output logic              ex_MemtoReg,
   output logic              ex_MemWrite,
   output logic              ex_RegWrite,
   output logic [1:0]        ex_Alu_src,
   output logic [2:0]        ex_Alu_op,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm_ext,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [4:0]        ex_shamt,
   output logic [5:0]        ex_funct,
   output logic              stall,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [1:0] ALU_SRC_ZEXT = 2'b10;

   // Unknown control bits from the decoder must never reach EX as anything but 0.
   function automatic logic clean_bit(input logic b);
      return (b === 1'b1) ? 1'b1 : 1'b0;
   endfunction

   function automatic logic [1:0] clean_vec2(input logic [1:0] v);
      return $isunknown(v) ? 2'b00 : v;
   endfunction

   function automatic logic [2:0] clean_vec3(input logic [2:0] v);
      return $isunknown(v) ? 3'b000 : v;
   endfunction

   function automatic logic [DATA_W-1:0] imm_extend(input logic [15:0] imm,
                                                    input logic [1:0]  src);
      logic [DATA_W-1:0] ext;
      case (src)
         ALU_SRC_ZEXT: ext = {{(DATA_W-16){1'b0}}, imm};
         default:      ext = {{(DATA_W-16){imm[15]}}, imm};
      endcase
      return ext;
   endfunction

   logic              valid_s;
   logic [7:0]        ctrl_s;
   logic [1:0]        alu_src_s;
   logic [2:0]        alu_op_s;
   logic              use_rs_s;
   logic              use_rt_s;
   logic              rs_match_s;
   logic              rt_match_s;
   logic              hazard_s;
   logic              bubble_s;
   logic              count_s;

   logic              ex_valid_r;
   logic [7:0]        ex_ctrl_r;
   logic [1:0]        ex_alu_src_r;
   logic [2:0]        ex_alu_op_r;
   logic [DATA_W-1:0] ex_pc4_r;
   logic [DATA_W-1:0] ex_rs_data_r;
   logic [DATA_W-1:0] ex_rt_data_r;
   logic [DATA_W-1:0] ex_imm_ext_r;
   logic [4:0]        ex_rs_r;
   logic [4:0]        ex_rt_r;
   logic [4:0]        ex_rd_r;
   logic [4:0]        ex_shamt_r;
   logic [5:0]        ex_funct_r;
   logic [CNT_W-1:0]  bubble_cnt_r;

   // Sanitise the decoder bundle; bit order is RegDst,J,Beq,Bneq,MemRead,MemtoReg,MemWrite,RegWrite.
   always_comb begin
      valid_s   = clean_bit(id_valid);
      ctrl_s    = {clean_bit(RegDst), clean_bit(J), clean_bit(Beq), clean_bit(Bneq),
                   clean_bit(MemRead), clean_bit(MemtoReg), clean_bit(MemWrite),
                   clean_bit(RegWrite)};
      alu_src_s = clean_vec2(Alu_src);
      alu_op_s  = clean_vec3(Alu_op);
   end

   // Load-use detection: a load in EX whose destination is read by the ID instruction.
   always_comb begin
      use_rs_s   = ~ctrl_s[6];
      use_rt_s   = ctrl_s[7] | ctrl_s[5] | ctrl_s[4] | ctrl_s[1];
      rs_match_s = use_rs_s & (ex_rt_r == id_rs);
      rt_match_s = use_rt_s & (ex_rt_r == id_rt);
      if (valid_s && ex_valid_r && ex_ctrl_r[3] && (ex_rt_r != 5'd0)) begin
         hazard_s = rs_match_s | rt_match_s;
      end else begin
         hazard_s = 1'b0;
      end
      // A flushed instruction dies anyway, so it never needs to be held.
      stall    = hazard_s & ~clean_bit(flush);
      count_s  = clean_bit(flush) | hazard_s;
      bubble_s = count_s | ~valid_s;
   end

   // Control half of the pipeline register: zeroed when a bubble is inserted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_r   <= 1'b0;
         ex_ctrl_r    <= 8'h00;
         ex_alu_src_r <= 2'b00;
         ex_alu_op_r  <= 3'b000;
      end else if (bubble_s) begin
         ex_valid_r   <= 1'b0;
         ex_ctrl_r    <= 8'h00;
         ex_alu_src_r <= 2'b00;
         ex_alu_op_r  <= 3'b000;
      end else begin
         ex_valid_r   <= 1'b1;
         ex_ctrl_r    <= ctrl_s;
         ex_alu_src_r <= alu_src_s;
         ex_alu_op_r  <= alu_op_s;
      end
   end

   // Data half of the pipeline register: loads every cycle, EX qualifies it with ex_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_pc4_r     <= {DATA_W{1'b0}};
         ex_rs_data_r <= {DATA_W{1'b0}};
         ex_rt_data_r <= {DATA_W{1'b0}};
         ex_imm_ext_r <= {DATA_W{1'b0}};
         ex_rs_r      <= 5'd0;
         ex_rt_r      <= 5'd0;
         ex_rd_r      <= 5'd0;
         ex_shamt_r   <= 5'd0;
         ex_funct_r   <= 6'd0;
      end else begin
         ex_pc4_r     <= id_pc4;
         ex_rs_data_r <= id_rs_data;
         ex_rt_data_r <= id_rt_data;
         ex_imm_ext_r <= imm_extend(id_imm, alu_src_s);
         ex_rs_r      <= id_rs;
         ex_rt_r      <= id_rt;
         ex_rd_r      <= id_rd;
         ex_shamt_r   <= id_shamt;
         ex_funct_r   <= id_funct;
      end
   end

   // Saturating count of flush and load-use bubbles; idle cycles are not counted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bubble_cnt_r <= {CNT_W{1'b0}};
      end else if (count_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
         bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         bubble_cnt_r <= bubble_cnt_r;
      end
   end

   assign ex_valid    = ex_valid_r;
   assign ex_RegDst   = ex_ctrl_r[7];
   assign ex_J        = ex_ctrl_r[6];
   assign ex_Beq      = ex_ctrl_r[5];
   assign ex_Bneq     = ex_ctrl_r[4];
   assign ex_MemRead  = ex_ctrl_r[3];
   assign ex_MemtoReg = ex_ctrl_r[2];
   assign ex_MemWrite = ex_ctrl_r[1];
   assign ex_RegWrite = ex_ctrl_r[0];
   assign ex_Alu_src  = ex_alu_src_r;
   assign ex_Alu_op   = ex_alu_op_r;
   assign ex_pc4      = ex_pc4_r;
   assign ex_rs_data  = ex_rs_data_r;
   assign ex_rt_data  = ex_rt_data_r;
   assign ex_imm_ext  = ex_imm_ext_r;
   assign ex_rs       = ex_rs_r;
   assign ex_rt       = ex_rt_r;
   assign ex_rd       = ex_rd_r;
   assign ex_shamt    = ex_shamt_r;
   assign ex_funct    = ex_funct_r;
   assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised scoreboard bench for id_ex_stage. It uses a behavioural model of the ID/EX register,
// the load-use rule and the bubble counter.
module tb_id_ex_stage;

   typedef struct {
      bit        id_valid, regdst, j, beq, bneq, memread, memtoreg, memwrite, regwrite, flush;
      bit [1:0]  alu_src;
      bit [2:0]  alu_op;
      bit [31:0] pc4, rs_data, rt_data;
      bit [15:0] imm;
      bit [4:0]  rs, rt, rd, shamt;
      bit [5:0]  funct;
   } in_t;

   typedef struct {
      bit        stall, valid;
      bit [7:0]  ctrl;
      bit [1:0]  alu_src;
      bit [2:0]  alu_op;
      bit [31:0] pc4, rs_data, rt_data, imm_ext;
      bit [4:0]  rs, rt, rd, shamt;
      bit [5:0]  funct;
      int        cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic id_valid, RegDst, J, Beq, Bneq, MemRead, MemtoReg, MemWrite, RegWrite, flush;
   logic [1:0]  Alu_src;
   logic [2:0]  Alu_op;
   logic [31:0] id_pc4, id_rs_data, id_rt_data;
   logic [15:0] id_imm;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [5:0]  id_funct;
   logic ex_valid, ex_RegDst, ex_J, ex_Beq, ex_Bneq, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite;
   logic [1:0]  ex_Alu_src;
   logic [2:0]  ex_Alu_op;
   logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [5:0]  ex_funct;
   logic        stall;
   logic [15:0] bubble_cnt;

   id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .RegDst(RegDst), .J(J), .Beq(Beq), .Bneq(Bneq), .MemRead(MemRead),
      .MemtoReg(MemtoReg), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .Alu_src(Alu_src), .Alu_op(Alu_op), .id_pc4(id_pc4),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_funct(id_funct), .flush(flush),
      .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_J(ex_J), .ex_Beq(ex_Beq),
      .ex_Bneq(ex_Bneq), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
      .ex_MemWrite(ex_MemWrite), .ex_RegWrite(ex_RegWrite),
      .ex_Alu_src(ex_Alu_src), .ex_Alu_op(ex_Alu_op), .ex_pc4(ex_pc4),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
      .ex_funct(ex_funct), .stall(stall), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   bit   stall_pre;

   // Model state: what EX should currently hold, as far as hazards and counting care.
   bit       m_valid, m_memread;
   bit [4:0] m_rt;
   int       m_cnt;
   bit       last_stall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input in_t x, input bit rst);
      exp_t e;
      bit   reads_rt, hz;
      @(negedge clk);
      rst_n = !rst;
      id_valid = x.id_valid; RegDst = x.regdst; J = x.j; Beq = x.beq; Bneq = x.bneq;
      MemRead = x.memread; MemtoReg = x.memtoreg; MemWrite = x.memwrite; RegWrite = x.regwrite;
      Alu_src = x.alu_src; Alu_op = x.alu_op; id_pc4 = x.pc4; id_rs_data = x.rs_data;
      id_rt_data = x.rt_data; id_imm = x.imm; id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
      id_shamt = x.shamt; id_funct = x.funct; flush = x.flush;
      // A load in EX writing a nonzero register that the ID instruction reads.
      reads_rt = x.regdst || x.beq || x.bneq || x.memwrite;
      hz = x.id_valid && m_valid && m_memread && (m_rt != 0) &&
           ((!x.j && m_rt == x.rs) || (reads_rt && m_rt == x.rt));
      e = '{default: 0};
      e.stall = hz && !x.flush;
      if (rst) begin
         m_cnt = 0;
      end else begin
         e.pc4 = x.pc4; e.rs_data = x.rs_data; e.rt_data = x.rt_data;
         e.rs = x.rs; e.rt = x.rt; e.rd = x.rd; e.shamt = x.shamt; e.funct = x.funct;
         e.imm_ext = (x.alu_src != 2 && x.imm >= 16'h8000) ? 32'(x.imm) + 32'hFFFF0000 : 32'(x.imm);
         if (x.id_valid && !x.flush && !hz) begin
            e.valid = 1;
            e.ctrl = {x.regdst, x.j, x.beq, x.bneq, x.memread, x.memtoreg, x.memwrite, x.regwrite};
            e.alu_src = x.alu_src;
            e.alu_op = x.alu_op;
         end
         if ((x.flush || hz) && m_cnt < 65535) m_cnt++;
      end
      e.cnt = m_cnt;
      m_valid = e.valid; m_memread = e.ctrl[3]; m_rt = e.rt;
      last_stall = e.stall;
      sb.push_back(e);
   endtask

   function automatic in_t rand_in();
      in_t x;
      x.id_valid = ($urandom_range(7) != 0);
      x.regdst = 1'($urandom_range(1));   x.j = ($urandom_range(3) == 0);
      x.beq = ($urandom_range(5) == 0);   x.bneq = ($urandom_range(5) == 0);
      x.memread = ($urandom_range(2) == 0);
      x.memtoreg = 1'($urandom_range(1)); x.memwrite = ($urandom_range(3) == 0);
      x.regwrite = 1'($urandom_range(1)); x.flush = ($urandom_range(7) == 0);
      x.alu_src = 2'($urandom_range(3));  x.alu_op = 3'($urandom_range(7));
      x.pc4 = $urandom; x.rs_data = $urandom; x.rt_data = $urandom;
      x.imm = 16'($urandom);
      x.rs = 5'($urandom_range(7)); x.rt = 5'($urandom_range(7));
      x.rd = 5'($urandom); x.shamt = 5'($urandom); x.funct = 6'($urandom);
      return x;
   endfunction

   // Sample the combinational stall just before the edge that consumes the inputs.
   initial forever begin
      @(negedge clk);
      #4;
      stall_pre = stall;
   end

   // Monitor: compare each registered response against the scoreboard after its edge.
   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("stall", 32'(stall_pre), 32'(e.stall));
         check("ex_valid", 32'(ex_valid), 32'(e.valid));
         check("ctrl", 32'({ex_RegDst, ex_J, ex_Beq, ex_Bneq, ex_MemRead, ex_MemtoReg,
                            ex_MemWrite, ex_RegWrite}), 32'(e.ctrl));
         check("alu_src", 32'(ex_Alu_src), 32'(e.alu_src));
         check("alu_op", 32'(ex_Alu_op), 32'(e.alu_op));
         check("pc4", ex_pc4, e.pc4);
         check("rs_data", ex_rs_data, e.rs_data);
         check("rt_data", ex_rt_data, e.rt_data);
         check("imm_ext", ex_imm_ext, e.imm_ext);
         check("idx", 32'({ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct}),
               32'({e.rs, e.rt, e.rd, e.shamt, e.funct}));
         check("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      in_t z, x, held;
      z = '{default: 0};
      z.id_valid = 1'b0;
      m_valid = 0; m_memread = 0; m_rt = 0; m_cnt = 0; last_stall = 0;
      for (int i = 0; i < 2; i++) step(rand_in(), 1'b1);
      @(posedge clk); #2;
      check("rst_valid", 32'(ex_valid), 32'd0);
      check("rst_cnt", 32'(bubble_cnt), 32'd0);

      // addi: sign-extended negative immediate
      x = z; x.id_valid = 1; x.regwrite = 1; x.memtoreg = 1; x.alu_src = 2'b01;
      x.imm = 16'hFFF0; x.rs = 5'd3; x.rt = 5'd4;
      step(x, 1'b0);
      #2 check("addi_stall", 32'(stall), 32'd0);
      @(posedge clk); #2;
      check("addi_imm", ex_imm_ext, 32'hFFFFFFF0);
      check("addi_valid", 32'(ex_valid), 32'd1);
      check("addi_rs_rt", 32'({ex_rs, ex_rt}), 32'({5'd3, 5'd4}));

      // ori: zero-extended immediate
      x = z; x.id_valid = 1; x.regwrite = 1; x.alu_src = 2'b10; x.imm = 16'h8001;
      step(x, 1'b0);
      @(posedge clk); #2;
      check("ori_imm", ex_imm_ext, 32'h00008001);

      // Load-use: lw $5 followed by add using $5, held for one cycle.
      x = z; x.id_valid = 1; x.memread = 1; x.memtoreg = 1; x.regwrite = 1;
      x.alu_src = 2'b01; x.rs = 5'd1; x.rt = 5'd5;
      step(x, 1'b0);
      held = z; held.id_valid = 1; held.regdst = 1; held.regwrite = 1;
      held.rs = 5'd5; held.rt = 5'd6; held.rd = 5'd7; held.funct = 6'h20;
      step(held, 1'b0);
      #2 check("lu_stall", 32'(stall), 32'd1);
      @(posedge clk); #2;
      check("lu_bubble", 32'({ex_valid, ex_MemRead, ex_RegWrite}), 32'd0);
      step(held, 1'b0);
      #2 check("lu_release", 32'(stall), 32'd0);
      @(posedge clk); #2;
      check("lu_add_valid", 32'(ex_valid), 32'd1);
      check("lu_add_rs", 32'(ex_rs), 32'd5);
      check("lu_cnt", 32'(bubble_cnt), 32'd1);

      // Load to $0 never stalls.
      x.rt = 5'd0;
      step(x, 1'b0);
      held.rs = 5'd0;
      step(held, 1'b0);
      #2 check("lu_r0_stall", 32'(stall), 32'd0);

      // Flush has priority over the hazard.
      x.rt = 5'd5;
      step(x, 1'b0);
      held.rs = 5'd5; held.flush = 1;
      step(held, 1'b0);
      #2 check("flush_stall", 32'(stall), 32'd0);
      @(posedge clk); #2;
      check("flush_valid", 32'(ex_valid), 32'd0);
      check("flush_cnt", 32'(bubble_cnt), 32'd2);

      // Randomised traffic; a stalled instruction is re-presented as the real pipeline would.
      held = rand_in();
      for (int i = 0; i < 3000; i++) begin
         if (!last_stall) held = rand_in();
         step(held, ($urandom_range(99) == 0));
      end

      // Saturation: reset then 2^16+3 flushes.
      step(z, 1'b1);
      x = z; x.flush = 1;
      for (int i = 0; i < 65539; i++) step(x, 1'b0);
      @(posedge clk); #2;
      check("sat_cnt", 32'(bubble_cnt), 32'h0000FFFF);

      @(posedge clk); #2;
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
